// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants for the multi-cycle RISC control unit.
//   - FSM state encodings (also visible on cpu_control_fsm.state_o)
//   - register-file write-source select codes
//   - ARM-style condition-code field values
//   - decoder opcode values, including the reserved invalid opcode
package cpu_pkg;

  // FSM state encodings; 5 and 6 are unused and trap to FAULT
  localparam logic [2:0] ST_FETCH   = 3'd0;
  localparam logic [2:0] ST_DECODE  = 3'd1;
  localparam logic [2:0] ST_EXECUTE = 3'd2;
  localparam logic [2:0] ST_MEM     = 3'd3;
  localparam logic [2:0] ST_WB      = 3'd4;
  localparam logic [2:0] ST_FAULT   = 3'd7;

  // Register-file write source
  localparam logic [1:0] RF_WSEL_ALU  = 2'b00;
  localparam logic [1:0] RF_WSEL_MEM  = 2'b01;
  localparam logic [1:0] RF_WSEL_LINK = 2'b10;

  // Condition field values
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Decoder opcodes; the control unit itself only distinguishes OP_INVALID
  localparam logic [4:0] OP_ADD     = 5'b00000;
  localparam logic [4:0] OP_SUB     = 5'b00001;
  localparam logic [4:0] OP_AND     = 5'b00010;
  localparam logic [4:0] OP_ORR     = 5'b00011;
  localparam logic [4:0] OP_CMP     = 5'b00100;
  localparam logic [4:0] OP_TST     = 5'b00101;
  localparam logic [4:0] OP_LDR     = 5'b01000;
  localparam logic [4:0] OP_STR     = 5'b01001;
  localparam logic [4:0] OP_B       = 5'b10000;
  localparam logic [4:0] OP_BL      = 5'b10001;
  localparam logic [4:0] OP_INVALID = 5'b11111;

endpackage

// File: rtl/cpu_control_fsm_cond_check.sv
// cond_check: combinational ARM condition evaluation.
// Ports:
//   condition  in  4  condition field from the decoder
//   nzcv       in  4  current flags {N,Z,C,V}
//   pass       out 1  instruction should execute
// NV (1111) never passes.
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] condition,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  always_comb begin
    pass = 1'b0;
    case (condition)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle control unit sequencing FETCH, DECODE,
// EXECUTE, MEM and WB, driving every datapath enable/select.
// Optional feature macro: COND_EXEC_EN (conditional execution via cond_check;
// when undefined every instruction passes and flags_nzcv is ignored).
// Parameter FETCH_TIMEOUT: nonzero = max FETCH wait cycles before FAULT.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   imem_ready, dmem_ready     memory handshakes
//   condition, opcode          decoder fields (opcode 5'b11111 = invalid)
//   reg_write_en .. flags_update_en  decoder control bits
//   flags_nzcv                 current flags {N,Z,C,V}
//   imem_req, ir_we, pc_we, pc_sel, opnd_we, alu_we, flags_we,
//   dmem_req, dmem_we, dmem_byte, rf_we, rf_wsel   datapath controls
//   retire                     one-cycle pulse per completed instruction
//   fault                      sticky illegal-instruction / timeout flag
//   state_o                    current state encoding
module cpu_control_fsm
  import cpu_pkg::*;
#(
  parameter int FETCH_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  input  logic [3:0] condition,
  input  logic [4:0] opcode,
  input  logic       reg_write_en,
  input  logic       mem_read_en,
  input  logic       mem_write_en,
  input  logic       mem_byte_en,
  input  logic       branch_en,
  input  logic       link_en,
  input  logic       flags_update_en,
  input  logic [3:0] flags_nzcv,
  output logic       imem_req,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_sel,
  output logic       opnd_we,
  output logic       alu_we,
  output logic       flags_we,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       dmem_byte,
  output logic       rf_we,
  output logic [1:0] rf_wsel,
  output logic       retire,
  output logic       fault,
  output logic [2:0] state_o
);

  localparam int CNT_W = (FETCH_TIMEOUT > 0) ? $clog2(FETCH_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(FETCH_TIMEOUT);

  logic [2:0]       state_q, state_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic             cond_pass;

`ifdef COND_EXEC_EN
  cond_check u_cond_check (
    .condition (condition),
    .nzcv      (flags_nzcv),
    .pass      (cond_pass)
  );
`else
  logic unused_cond;
  assign unused_cond = ^{condition, flags_nzcv};
  assign cond_pass   = 1'b1;
`endif

  // Next-state and output decode. The timeout counter defaults to zero so it
  // only accumulates across consecutive FETCH wait cycles and is clear on
  // every FETCH entry. Undefined encodings trap to FAULT.
  always_comb begin
    state_d   = state_q;
    tmo_d     = '0;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 1'b0;
    opnd_we   = 1'b0;
    alu_we    = 1'b0;
    flags_we  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    dmem_byte = 1'b0;
    rf_we     = 1'b0;
    rf_wsel   = RF_WSEL_ALU;
    retire    = 1'b0;

    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (FETCH_TIMEOUT != 0) begin
          if ((tmo_q + CNT_W'(1)) == TIMEOUT_LIMIT) state_d = ST_FAULT;
          else                                      tmo_d   = tmo_q + CNT_W'(1);
        end
      end

      ST_DECODE: begin
        opnd_we = 1'b1;
        if (opcode == OP_INVALID) begin
          state_d = ST_FAULT;
        end else if (!cond_pass) begin
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EXECUTE;
        end
      end

      ST_EXECUTE: begin
        alu_we   = 1'b1;
        flags_we = flags_update_en;
        if (branch_en) begin
          pc_we   = 1'b1;
          pc_sel  = 1'b1;
          rf_we   = link_en;
          rf_wsel = link_en ? RF_WSEL_LINK : RF_WSEL_ALU;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else if (mem_read_en || mem_write_en) begin
          state_d = ST_MEM;
        end else if (reg_write_en) begin
          state_d = ST_WB;
        end else begin
          retire  = 1'b1;
          state_d = ST_FETCH;
        end
      end

      ST_MEM: begin
        dmem_req  = 1'b1;
        dmem_we   = mem_write_en;
        dmem_byte = mem_byte_en;
        if (dmem_ready) begin
          if (mem_read_en) begin
            state_d = ST_WB;
          end else begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end

      ST_WB: begin
        rf_we   = 1'b1;
        rf_wsel = mem_read_en ? RF_WSEL_MEM : RF_WSEL_ALU;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end

      ST_FAULT: state_d = ST_FAULT;

      default: state_d = ST_FAULT;
    endcase
  end

  // fault is set together with the FAULT state so both are visible on the
  // same cycle, and only reset can clear it.
  always_comb begin
    fault_d = fault_q || (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      fault_q <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      tmo_q   <= tmo_d;
    end
  end

  assign fault   = fault_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb_cpu_control_fsm: self-checking bench for cpu_control_fsm.
// A reference model expands each instruction into its expected per-cycle
// trace (state, outputs, ready inputs to drive) from the architectural
// rules; each test replays its trace and compares every cycle.
// Honours COND_EXEC_EN to pick the expected condition behaviour.
module tb_cpu_control_fsm;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       imem_ready, dmem_ready;
  logic [3:0] condition;
  logic [4:0] opcode;
  logic       reg_write_en, mem_read_en, mem_write_en, mem_byte_en;
  logic       branch_en, link_en, flags_update_en;
  logic [3:0] flags_nzcv;
  logic       imem_req, ir_we, pc_we, pc_sel, opnd_we, alu_we, flags_we;
  logic       dmem_req, dmem_we, dmem_byte, rf_we, retire, fault;
  logic [1:0] rf_wsel;
  logic [2:0] state_o;

  cpu_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .condition(condition), .opcode(opcode), .reg_write_en(reg_write_en),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_byte_en(mem_byte_en),
    .branch_en(branch_en), .link_en(link_en), .flags_update_en(flags_update_en),
    .flags_nzcv(flags_nzcv), .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .opnd_we(opnd_we), .alu_we(alu_we), .flags_we(flags_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_byte(dmem_byte), .rf_we(rf_we),
    .rf_wsel(rf_wsel), .retire(retire), .fault(fault), .state_o(state_o)
  );

  always #5 clk = ~clk;

  logic [14:0] dut_outs;
  assign dut_outs = {imem_req, ir_we, pc_we, pc_sel, opnd_we, alu_we, flags_we,
                     dmem_req, dmem_we, dmem_byte, rf_we, rf_wsel, retire, fault};

  localparam logic [14:0] O_IMEM = 15'h4000, O_IR    = 15'h2000, O_PC   = 15'h1000;
  localparam logic [14:0] O_PCSEL = 15'h0800, O_OPND = 15'h0400, O_ALU  = 15'h0200;
  localparam logic [14:0] O_FLAGS = 15'h0100, O_DREQ = 15'h0080, O_DWE  = 15'h0040;
  localparam logic [14:0] O_DBYTE = 15'h0020, O_RFWE = 15'h0010, O_WLNK = 15'h0008;
  localparam logic [14:0] O_WMEM  = 15'h0004, O_RET  = 15'h0002, O_FLT  = 15'h0001;

  localparam logic [2:0] S_FETCH = 3'd0, S_DEC = 3'd1, S_EX = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3, S_WB = 3'd4, S_FLT = 3'd7;

  localparam int K_ALU = 0, K_CMP = 1, K_LDR = 2, K_STR = 3, K_B = 4, K_BL = 5, K_BAD = 6;

  typedef struct packed {
    logic        imr;
    logic        dmr;
    logic [2:0]  st;
    logic [14:0] outs;
  } step_t;

  typedef struct {
    int         kind;
    logic [4:0] op;
    logic [3:0] cond;
    logic [3:0] nzcv;
    logic       fu;
    logic       byt;
    int         fw;
    int         dw;
  } instr_t;

  step_t tr[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Architectural condition rule: pairs of codes test one predicate, the odd
  // code of each pair is its negation; 1111 never executes.
  function automatic logic model_pass(input logic [3:0] c, input logic [3:0] f);
`ifdef COND_EXEC_EN
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return c[0] ? ~base : base;
`else
    return ((c ^ f) == 8'd0) || 1'b1;
`endif
  endfunction

  task automatic push(input logic imr, input logic dmr, input logic [2:0] st,
                      input logic [14:0] outs);
    step_t s;
    s.imr = imr; s.dmr = dmr; s.st = st; s.outs = outs;
    tr.push_back(s);
  endtask

  task automatic set_decoder(input instr_t ins);
    opcode          = ins.op;
    condition       = ins.cond;
    flags_nzcv      = ins.nzcv;
    reg_write_en    = (ins.kind == K_ALU) || (ins.kind == K_LDR);
    mem_read_en     = (ins.kind == K_LDR);
    mem_write_en    = (ins.kind == K_STR);
    mem_byte_en     = ins.byt;
    branch_en       = (ins.kind == K_B) || (ins.kind == K_BL);
    link_en         = (ins.kind == K_BL);
    flags_update_en = ins.fu;
    if (ins.kind == K_BAD) begin
      reg_write_en = rnd_bit(); mem_read_en = rnd_bit(); mem_write_en = rnd_bit();
      branch_en    = rnd_bit(); link_en     = rnd_bit();
    end
  endtask

  // Expected per-cycle behaviour of one instruction, FETCH through retire.
  task automatic build_trace(input instr_t ins);
    logic [14:0] ex, mo;
    for (int i = 0; i < ins.fw; i++) push(1'b0, rnd_bit(), S_FETCH, O_IMEM);
    push(1'b1, rnd_bit(), S_FETCH, O_IMEM | O_IR | O_PC);
    if (ins.kind == K_BAD) begin
      push(rnd_bit(), rnd_bit(), S_DEC, O_OPND);
      return;
    end
    if (!model_pass(ins.cond, ins.nzcv)) begin
      push(rnd_bit(), rnd_bit(), S_DEC, O_OPND | O_RET);
      return;
    end
    push(rnd_bit(), rnd_bit(), S_DEC, O_OPND);
    ex = O_ALU | (ins.fu ? O_FLAGS : 15'h0);
    case (ins.kind)
      K_B:   push(rnd_bit(), rnd_bit(), S_EX, ex | O_PC | O_PCSEL | O_RET);
      K_BL:  push(rnd_bit(), rnd_bit(), S_EX, ex | O_PC | O_PCSEL | O_RFWE | O_WLNK | O_RET);
      K_CMP: push(rnd_bit(), rnd_bit(), S_EX, ex | O_RET);
      K_ALU: begin
        push(rnd_bit(), rnd_bit(), S_EX, ex);
        push(rnd_bit(), rnd_bit(), S_WB, O_RFWE | O_RET);
      end
      default: begin
        push(rnd_bit(), rnd_bit(), S_EX, ex);
        mo = O_DREQ | ((ins.kind == K_STR) ? O_DWE : 15'h0) | (ins.byt ? O_DBYTE : 15'h0);
        for (int i = 0; i < ins.dw; i++) push(rnd_bit(), 1'b0, S_MEM, mo);
        push(rnd_bit(), 1'b1, S_MEM, mo | ((ins.kind == K_STR) ? O_RET : 15'h0));
        if (ins.kind == K_LDR) push(rnd_bit(), rnd_bit(), S_WB, O_RFWE | O_WMEM | O_RET);
      end
    endcase
  endtask

  function automatic instr_t mk(input int kind, input logic [4:0] op, input logic [3:0] cond,
                                input logic [3:0] nzcv, input int fw, input int dw);
    instr_t i;
    i.kind = kind; i.op = op; i.cond = cond; i.nzcv = nzcv;
    i.fu = 1'b0; i.byt = 1'b0; i.fw = fw; i.dw = dw;
    return i;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    set_decoder(mk(K_ALU, OP_ADD, COND_AL, 4'h0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({state_o, dut_outs} !== {S_FETCH, O_IMEM})
      $display("[TB] FAIL reset_hold: got state=%0d outs=%h, expected state=%0d outs=%h",
               state_o, dut_outs, S_FETCH, O_IMEM);
    else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({state_o, dut_outs} !== {S_FETCH, O_IMEM})
      $display("[TB] FAIL reset_release: got state=%0d outs=%h, expected state=%0d outs=%h",
               state_o, dut_outs, S_FETCH, O_IMEM);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    tr.delete();
    set_decoder(mk(K_ALU, OP_ADD, COND_AL, 4'($urandom_range(0, 15)), 0, 0));
    build_trace(mk(K_ALU, OP_ADD, COND_AL, flags_nzcv, 0, 0));
    for (int i = 0; i < tr.size(); i++) begin
      imem_ready = tr[i].imr; dmem_ready = tr[i].dmr;
      @(negedge clk);
      n_checks++;
      if ({state_o, dut_outs} !== {tr[i].st, tr[i].outs})
        $display("[TB] FAIL add cyc%0d: got state=%0d outs=%h, expected state=%0d outs=%h",
                 i, state_o, dut_outs, tr[i].st, tr[i].outs);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ldr_wait();
    instr_t ins;
    ins = mk(K_LDR, OP_LDR, COND_AL, 4'h0, 0, 2);
    ins.byt = 1'b1;
    tr.delete();
    set_decoder(ins);
    build_trace(ins);
    for (int i = 0; i < tr.size(); i++) begin
      imem_ready = tr[i].imr; dmem_ready = tr[i].dmr;
      @(negedge clk);
      n_checks++;
      if ({state_o, dut_outs} !== {tr[i].st, tr[i].outs})
        $display("[TB] FAIL ldr_wait cyc%0d: got state=%0d outs=%h, expected state=%0d outs=%h",
                 i, state_o, dut_outs, tr[i].st, tr[i].outs);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_bl();
    instr_t ins;
    ins = mk(K_BL, OP_BL, COND_AL, 4'hF, 1, 0);
    ins.fu = 1'b1;
    tr.delete();
    set_decoder(ins);
    build_trace(ins);
    for (int i = 0; i < tr.size(); i++) begin
      imem_ready = tr[i].imr; dmem_ready = tr[i].dmr;
      @(negedge clk);
      n_checks++;
      if ({state_o, dut_outs} !== {tr[i].st, tr[i].outs})
        $display("[TB] FAIL bl cyc%0d: got state=%0d outs=%h, expected state=%0d outs=%h",
                 i, state_o, dut_outs, tr[i].st, tr[i].outs);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  // BEQ with Z clear, then with Z set, then an NV-coded ADD.
  task automatic test_beq_cond();
    instr_t seq[3];
    seq[0] = mk(K_B, OP_B, COND_EQ, 4'b0000, 0, 0);
    seq[1] = mk(K_B, OP_B, COND_EQ, 4'b0100, 0, 0);
    seq[2] = mk(K_ALU, OP_ADD, COND_NV, 4'b1010, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tr.delete();
      set_decoder(seq[k]);
      build_trace(seq[k]);
      for (int i = 0; i < tr.size(); i++) begin
        imem_ready = tr[i].imr; dmem_ready = tr[i].dmr;
        @(negedge clk);
        n_checks++;
        if ({state_o, dut_outs} !== {tr[i].st, tr[i].outs})
          $display("[TB] FAIL cond%0d cyc%0d: got state=%0d outs=%h, expected state=%0d outs=%h",
                   k, i, state_o, dut_outs, tr[i].st, tr[i].outs);
        else n_pass++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_fault();
    instr_t ins;
    ins = mk(K_BAD, OP_INVALID, COND_AL, 4'h0, 0, 0);
    tr.delete();
    set_decoder(ins);
    build_trace(ins);
    for (int i = 0; i < 20; i++) push(rnd_bit(), rnd_bit(), S_FLT, O_FLT);
    for (int i = 0; i < tr.size(); i++) begin
      imem_ready = tr[i].imr; dmem_ready = tr[i].dmr;
      @(negedge clk);
      n_checks++;
      if ({state_o, dut_outs} !== {tr[i].st, tr[i].outs})
        $display("[TB] FAIL fault cyc%0d: got state=%0d outs=%h, expected state=%0d outs=%h",
                 i, state_o, dut_outs, tr[i].st, tr[i].outs);
      else n_pass++;
      @(posedge clk); #1;
    end
    imem_ready = 1'b0; dmem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({state_o, dut_outs} !== {S_FETCH, O_IMEM})
      $display("[TB] FAIL fault_clear: got state=%0d outs=%h, expected state=%0d outs=%h",
               state_o, dut_outs, S_FETCH, O_IMEM);
    else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_mem();
    instr_t ins;
    ins = mk(K_STR, OP_STR, COND_AL, 4'h0, 0, 6);
    tr.delete();
    set_decoder(ins);
    build_trace(ins);
    for (int i = 0; i < 4; i++) begin
      imem_ready = tr[i].imr; dmem_ready = tr[i].dmr;
      @(negedge clk);
      n_checks++;
      if ({state_o, dut_outs} !== {tr[i].st, tr[i].outs})
        $display("[TB] FAIL rst_mem cyc%0d: got state=%0d outs=%h, expected state=%0d outs=%h",
                 i, state_o, dut_outs, tr[i].st, tr[i].outs);
      else n_pass++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (dmem_req !== 1'b1)
      $display("[TB] FAIL rst_mem_pre: got dmem_req=%b, expected 1", dmem_req);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({state_o, dmem_req, imem_req} !== {S_FETCH, 1'b0, 1'b1})
      $display("[TB] FAIL rst_mem_drop: got state=%0d dmem_req=%b imem_req=%b, expected 0/0/1",
               state_o, dmem_req, imem_req);
    else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({state_o, dut_outs} !== {S_FETCH, O_IMEM})
      $display("[TB] FAIL rst_mem_release: got state=%0d outs=%h, expected state=%0d outs=%h",
               state_o, dut_outs, S_FETCH, O_IMEM);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    instr_t ins;
    for (int k = 0; k < 60; k++) begin
      ins.kind = $urandom_range(K_ALU, K_BL);
      ins.op   = 5'($urandom_range(0, 30));
      ins.cond = 4'($urandom_range(0, 15));
      ins.nzcv = 4'($urandom_range(0, 15));
      ins.fu   = rnd_bit();
      ins.byt  = rnd_bit();
      ins.fw   = $urandom_range(0, 2);
      ins.dw   = $urandom_range(0, 2);
      tr.delete();
      set_decoder(ins);
      build_trace(ins);
      for (int i = 0; i < tr.size(); i++) begin
        imem_ready = tr[i].imr; dmem_ready = tr[i].dmr;
        @(negedge clk);
        n_checks++;
        if ({state_o, dut_outs} !== {tr[i].st, tr[i].outs})
          $display("[TB] FAIL rand%0d kind%0d cyc%0d: got state=%0d outs=%h, expected state=%0d outs=%h",
                   k, ins.kind, i, state_o, dut_outs, tr[i].st, tr[i].outs);
        else n_pass++;
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ldr_wait();
    test_bl();
    test_beq_cond();
    test_fault();
    test_reset_mid_mem();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_control_fsm.md
# cpu_control_fsm

Multi-cycle control unit for the RISC core. It takes the instruction decoder's control outputs and the current NZCV flags, and sequences fetch, decode, execute, memory and write-back. It drives every enable and select in the datapath: PC, IR, operand latches, ALU result register, data memory, register file and flags. It sits between the instruction decoder and the datapath, and handshakes with instruction memory and data memory.

## Interface
Parameters:
- `FETCH_TIMEOUT`, default 0. If nonzero, the number of cycles FETCH may wait on `imem_ready` before entering FAULT. 0 disables the timeout.

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `imem_ready`  in  1  instruction word valid this cycle
- `dmem_ready`  in  1  data access complete this cycle
- `condition`  in  4  decoder condition field
- `opcode`  in  5  decoder opcode; 5'b11111 = invalid
- `reg_write_en`, `mem_read_en`, `mem_write_en`, `mem_byte_en`, `branch_en`, `link_en`, `flags_update_en`  in  1 each  decoder control bits
- `flags_nzcv`  in  4  current flags {N,Z,C,V}
- `imem_req`  out  1  instruction fetch request
- `ir_we`  out  1  load instruction register
- `pc_we`  out  1  update PC
- `pc_sel`  out  1  0 = PC+4, 1 = branch target
- `opnd_we`  out  1  latch register-file operands
- `alu_we`  out  1  latch ALU result
- `flags_we`  out  1  write NZCV
- `dmem_req`, `dmem_we`, `dmem_byte`  out  1 each  data memory request, write, byte access
- `rf_we`  out  1  register-file write
- `rf_wsel`  out  2  write source: 00 ALU, 01 memory, 10 link (PC)
- `retire`  out  1  one-cycle pulse per completed instruction
- `fault`  out  1  sticky illegal-instruction/timeout indicator
- `state_o`  out  3  current state encoding

## Operation
States: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, FAULT=7.

- **FETCH:** `imem_req`=1.
  - On `imem_ready`: pulse `ir_we`, `pc_we` (`pc_sel`=0), then go to DECODE.
  - Otherwise hold.
- **DECODE:** `opnd_we`=1. Evaluate the condition against `flags_nzcv` using ARM semantics (0000 EQ … 1110 AL; 1111 never passes).
  - `opcode`==5'b11111 → FAULT.
  - Condition fails → FETCH, with a `retire` pulse and no other side effects.
  - Otherwise → EXECUTE.
- **EXECUTE:** `alu_we`=1. `flags_we`=`flags_update_en`. Then:
  - `branch_en`: `pc_we`=1, `pc_sel`=1. If `link_en`, also `rf_we`=1 and `rf_wsel`=10. `retire` pulses. → FETCH.
  - `mem_read_en` or `mem_write_en` → MEM.
  - `reg_write_en` → WB.
  - Otherwise (compare/test) → FETCH with `retire`.
- **MEM:** `dmem_req`=1. `dmem_we`=`mem_write_en`. `dmem_byte`=`mem_byte_en`. Hold until `dmem_ready`.
  - Load → WB.
  - Store → FETCH with `retire`.
- **WB:** `rf_we`=1. `rf_wsel`=01 if `mem_read_en`, else 00. `retire` pulses. → FETCH.
- **FAULT:** terminal. All enables are 0 and `fault`=1 until reset.
- Decoder inputs must be stable from DECODE through WB; the IR is not rewritten until the next FETCH.
- The condition is evaluated once, in DECODE. A flags write in EXECUTE does not re-qualify the current instruction.

## Timing
- Reset: state = FETCH. Every output is 0 except `imem_req`, which is 1 because the FETCH decode is combinational. `fault`=0. Timeout counter = 0.
- All outputs are a combinational decode of the state register and inputs (Moore plus ready qualification). State and `fault` are registered.
- Latency with zero-wait memory, counted from the FETCH accept cycle through the `retire` cycle:
  - branch: 3
  - ALU op: 4
  - store: 4
  - load: 5
  - condition-failed: 2
- Each wait cycle on `imem_ready` or `dmem_ready` adds exactly one cycle.
- `retire` is exactly one cycle wide.
- Reset asserted mid-access drops `imem_req`/`dmem_req` immediately; no handshake completion is required.
- The timeout counter clears on every FETCH entry. When it reaches `FETCH_TIMEOUT`, the next state is FAULT.

## Configuration
- `COND_EXEC_EN` defined: condition evaluation active, as described in Operation.
- `COND_EXEC_EN` undefined:
  - Every instruction passes its condition; `flags_nzcv` is ignored.
  - The condition-failed path does not exist.
  - 1111 executes normally.

## Structure
- Shared package `cpu_pkg`:
  - state encodings
  - `rf_wsel` codes
  - condition-code constants
  - `OP_*` opcode constants, including the invalid opcode 5'b11111
- One sub-module, `cond_check`: combinational, 4-bit condition plus NZCV in, 1-bit pass out. It is instantiated only under `COND_EXEC_EN`.

## Test plan
- ADD, AL, zero-wait memory → states 0,1,2,4; `rf_we`=1 and `rf_wsel`=00 in cycle 4; `retire` in cycle 4.
- LDR, `dmem_ready` delayed 2 cycles → MEM held 3 cycles; `rf_wsel`=01 in WB; 7 cycles total.
- BL, AL → EXECUTE shows `pc_we`=1, `pc_sel`=1, `rf_we`=1, `rf_wsel`=10 in the same cycle; next state FETCH.
- BEQ with Z=0 (condition 0000) → DECODE then FETCH; no `pc_sel`=1 and no `rf_we`. With `COND_EXEC_EN` undefined, the same stimulus takes the branch.
- `opcode`=5'b11111 → FAULT entered after DECODE; `fault`=1 and all enables 0 for 20 cycles; `rst_n` low clears it.
- `rst_n` pulsed low during MEM with `dmem_req`=1 → `dmem_req` drops in the same cycle; state 0 after release.
